linear_diffusion_inv_iter: RTL and testbench

//  Iterative inverse of the Ascon linear diffusion layer (p_L^-1), per word:

---
 rtl/linear_diffusion_inv_iter_pkg.sv | 35 +++
 rtl/linear_diffusion_inv_iter_if.sv | 38 +++
 rtl/linear_diffusion_inv_iter_ld_pow2_step.sv | 25 ++
 rtl/linear_diffusion_inv_iter.sv | 104 ++++++++++
 tb/tb_linear_diffusion_inv_iter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/linear_diffusion_inv_iter_pkg.sv
// ============================================================================
// Module  : linear_diffusion_inv_iter_pkg
// Brief   : Shared Ascon state type, linear diffusion rotation constants and
//           helpers for the iterative inverse linear layer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package linear_diffusion_inv_iter_pkg;

  typedef logic [4:0][63:0] ascon_state_t;

  // Word i rotates by LD_ROT_A[i] and LD_ROT_B[i]; the forward layer uses the same table
  localparam logic [4:0][5:0] LD_ROT_A = {6'd7, 6'd10, 6'd1, 6'd61, 6'd19};
  localparam logic [4:0][5:0] LD_ROT_B = {6'd41, 6'd17, 6'd6, 6'd39, 6'd28};
  localparam int LD_INV_STEPS = 6;

  typedef enum logic [1:0] {
    LDI_IDLE = 2'd0,
    LDI_BUSY = 2'd1,
    LDI_DONE = 2'd2
  } ld_inv_fsm_t;

  // Rotation amount for Sigma^(2^k): (r << k) mod 64
  function automatic logic [5:0] ld_rot_amt(input logic [5:0] r, input logic [2:0] k);
    return r << k;
  endfunction

  function automatic logic [63:0] ld_ror(input logic [63:0] x, input logic [5:0] n);
    return (x >> n) | (x << (7'd64 - {1'b0, n}));
  endfunction

endpackage

`default_nettype wire

// File: rtl/linear_diffusion_inv_iter_if.sv
// ============================================================================
// Module  : linear_diffusion_inv_iter_if
// Brief   : Valid/ready input and output channels of the inverse linear layer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface linear_diffusion_inv_iter_if;
  import linear_diffusion_inv_iter_pkg::*;

  logic         in_valid_i;
  logic         in_ready_o;
  ascon_state_t state_array_i;
  logic         out_valid_o;
  logic         out_ready_i;
  ascon_state_t state_array_o;

  modport slave (
    input  in_valid_i,
    input  state_array_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output state_array_o
  );

  modport master (
    output in_valid_i,
    output state_array_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  state_array_o
  );

endinterface

`default_nettype wire

// File: rtl/linear_diffusion_inv_iter_ld_pow2_step.sv
// ============================================================================
// Module  : ascon_ld_pow2_step
// Brief   : Combinational Sigma_i^(2^k) applied to all five state words.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ascon_ld_pow2_step
  import linear_diffusion_inv_iter_pkg::*;
(
  input  ascon_state_t i_state,
  input  logic [2:0]   i_k,
  output ascon_state_t o_state
);

  // A zero rotation amount is left in: the term then cancels x, which is the correct algebra
  for (genvar i = 0; i < 5; i++) begin : g_word
    assign o_state[i] = i_state[i]
                      ^ ld_ror(i_state[i], ld_rot_amt(LD_ROT_A[i], i_k))
                      ^ ld_ror(i_state[i], ld_rot_amt(LD_ROT_B[i], i_k));
  end

endmodule

`default_nettype wire

// File: rtl/linear_diffusion_inv_iter.sv
// ============================================================================
// Module  : linear_diffusion_inv_iter
// Brief   : Iterative inverse Ascon linear layer, Sigma^-1 = prod Sigma^(2^k),
//           k = 0..5, STEPS_PER_CYCLE steps per cycle behind valid/ready.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module linear_diffusion_inv_iter
  import linear_diffusion_inv_iter_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  linear_diffusion_inv_iter_if.slave     bus
);

  if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 ||
        STEPS_PER_CYCLE == 3 || STEPS_PER_CYCLE == 6)) begin : g_bad_spc
    $error("STEPS_PER_CYCLE must be 1, 2, 3 or 6");
  end

  localparam logic [2:0] c_spc = 3'(STEPS_PER_CYCLE);

  ld_inv_fsm_t  r_state;
  ld_inv_fsm_t  w_next_state;
  ascon_state_t r_data;
  logic [2:0]   r_step;
  logic         w_accept;
  logic         w_last_step;
  logic         w_in_ready;
  logic         w_out_valid;
  ascon_state_t w_chain [STEPS_PER_CYCLE+1];

  assign w_chain[0] = r_data;

  for (genvar j = 0; j < STEPS_PER_CYCLE; j++) begin : g_chain
    ascon_ld_pow2_step u_step (
      .i_state (w_chain[j]),
      .i_k     (3'(r_step + 3'(j))),
      .o_state (w_chain[j+1])
    );
  end

  assign w_accept    = bus.in_valid_i & w_in_ready;
  // Widened so the compare cannot wrap
  assign w_last_step = ({1'b0, r_step} + {1'b0, c_spc}) == 4'(LD_INV_STEPS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= LDI_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LDI_IDLE: if (bus.in_valid_i) w_next_state = LDI_BUSY;
      LDI_BUSY: if (w_last_step)    w_next_state = LDI_DONE;
      LDI_DONE: begin
        if (bus.out_ready_i) begin
          w_next_state = bus.in_valid_i ? LDI_BUSY : LDI_IDLE;
        end
      end
      default:  w_next_state = LDI_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      LDI_IDLE: w_in_ready = 1'b1;
      LDI_DONE: begin
        w_in_ready  = bus.out_ready_i;
        w_out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data <= '0;
      r_step <= 3'd0;
    end else if (w_accept) begin
      r_data <= bus.state_array_i;
      r_step <= 3'd0;
    end else if (r_state == LDI_BUSY) begin
      r_data <= w_chain[STEPS_PER_CYCLE];
      r_step <= r_step + c_spc;
    end
  end

  assign bus.in_ready_o    = w_in_ready;
  assign bus.out_valid_o   = w_out_valid;
  assign bus.state_array_o = r_data;

endmodule

`default_nettype wire

// File: tb/tb_linear_diffusion_inv_iter.sv
// ============================================================================
// Module  : tb_linear_diffusion_inv_iter
// Brief   : Checks three instances (1, 3, 6 steps/cycle) against the forward
//           linear layer: forward(inverse(y)) == y and inverse(forward(x)) == x.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_linear_diffusion_inv_iter;
  import linear_diffusion_inv_iter_pkg::*;

  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};
  localparam int LAT [3] = '{6, 2, 1};
  localparam int BUSY_RST [3] = '{3, 2, 1};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  ascon_state_t state_in = '0;
  int           sel = 0;

  logic         rdy;
  logic         vld;
  ascon_state_t dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  linear_diffusion_inv_iter_if if0 ();
  linear_diffusion_inv_iter_if if1 ();
  linear_diffusion_inv_iter_if if2 ();

  linear_diffusion_inv_iter #(.STEPS_PER_CYCLE(1)) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  linear_diffusion_inv_iter #(.STEPS_PER_CYCLE(3)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  linear_diffusion_inv_iter #(.STEPS_PER_CYCLE(6)) u_dut2 (.clk_i(clk), .rst_i(rst), .bus(if2));

  assign if0.in_valid_i    = in_valid && (sel == 0);
  assign if1.in_valid_i    = in_valid && (sel == 1);
  assign if2.in_valid_i    = in_valid && (sel == 2);
  assign if0.out_ready_i   = out_ready && (sel == 0);
  assign if1.out_ready_i   = out_ready && (sel == 1);
  assign if2.out_ready_i   = out_ready && (sel == 2);
  assign if0.state_array_i = state_in;
  assign if1.state_array_i = state_in;
  assign if2.state_array_i = state_in;

  always_comb begin
    rdy  = if0.in_ready_o;
    vld  = if0.out_valid_o;
    dout = if0.state_array_o;
    if (sel == 1) begin
      rdy  = if1.in_ready_o;
      vld  = if1.out_valid_o;
      dout = if1.state_array_o;
    end else if (sel == 2) begin
      rdy  = if2.in_ready_o;
      vld  = if2.out_valid_o;
      dout = if2.state_array_o;
    end
  end

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Forward Ascon linear diffusion layer
  function automatic ascon_state_t ld(input ascon_state_t s);
    ascon_state_t r;
    for (int i = 0; i < 5; i++) r[i] = s[i] ^ rotr(s[i], RA[i]) ^ rotr(s[i], RB[i]);
    return r;
  endfunction

  function automatic ascon_state_t rand_state();
    ascon_state_t s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s sel=%0d observed %h expected %h", tag, sel, obs, exp);
    end
  endtask

  // Starts one cycle after the accepting edge; returns the result and consumes it
  task automatic wait_result(output ascon_state_t res, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #2;
    end while (!vld && lat < 20);
    res = dout;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_txn(input ascon_state_t din, output ascon_state_t res, output int lat);
    int n;
    state_in  = din;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    n = 0;
    while (!rdy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(res, lat);
  endtask

  task automatic random_inverse(input int count);
    ascon_state_t x, res;
    int lat;
    for (int t = 0; t < count; t++) begin
      x = rand_state();
      run_txn(ld(x), res, lat);
      chk("rand_inv", res, x);
      chk("rand_lat", 320'(lat), 320'(LAT[sel]));
    end
  endtask

  task automatic random_forward(input int count);
    ascon_state_t y, res;
    int lat;
    for (int t = 0; t < count; t++) begin
      y = rand_state();
      run_txn(y, res, lat);
      chk("fwd_of_inv", ld(res), y);
    end
  endtask

  task automatic zero_test();
    ascon_state_t res;
    int lat;
    run_txn('0, res, lat);
    chk("zero_lat", 320'(lat), 320'(LAT[sel]));
    chk("zero_out", res, '0);
  endtask

  task automatic reset_mid_busy();
    ascon_state_t x, res;
    int lat;
    x = rand_state();
    state_in  = ld(x);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (BUSY_RST[sel] - 1) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async", {vld, rdy, dout}, {1'b0, 1'b1, 320'd0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    x = rand_state();
    run_txn(ld(x), res, lat);
    chk("post_rst", res, x);
    chk("post_rst_lat", 320'(lat), 320'(LAT[sel]));
  endtask

  initial begin
    ascon_state_t s, x, x2, res, hold;
    ascon_state_t bx [4];
    ascon_state_t bres [4];
    int acc_cyc [4];
    int lat, idx, nres, cyc, n;
    logic acc;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      chk("reset_state", {vld, rdy, dout}, {1'b0, 1'b1, 320'd0});
    end
    sel = 0;
    @(posedge clk);
    #1;

    zero_test();

    // Single-bit preimages through the forward layer
    for (int w = 0; w < 5; w++) begin
      s = '0;
      s[w] = (w == 0) ? 64'h1 : 64'h2;
      run_txn(ld(s), res, lat);
      chk("unit_vec", res, s);
    end

    random_inverse(500);
    random_forward(20);

    // Backpressure: result held while out_ready is low, new input refused
    x  = rand_state();
    x2 = rand_state();
    state_in = ld(x);
    in_valid = 1'b1;
    #1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!vld && n < 20);
    hold = dout;
    chk("bp_result", hold, x);
    state_in = ld(x2);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #2;
      chk("bp_hold", {vld, rdy, dout}, {1'b1, 1'b0, hold});
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 320'(rdy), 320'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    wait_result(res, lat);
    chk("bp_next", res, x2);
    chk("bp_next_lat", 320'(lat), 320'(LAT[0]));

    // Back-to-back with in_valid and out_ready held high
    for (int i = 0; i < 4; i++) bx[i] = rand_state();
    state_in  = ld(bx[0]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    idx = 0;
    nres = 0;
    cyc = 0;
    #1;
    while (nres < 4 && cyc < 100) begin
      acc = in_valid && rdy;
      if (vld) begin
        bres[nres] = dout;
        nres++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (acc && idx < 4) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 4) state_in = ld(bx[idx]);
        else in_valid = 1'b0;
      end
      #1;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_count", 320'(nres), 320'd4);
    for (int i = 0; i < nres; i++) chk("b2b_data", bres[i], bx[i]);
    for (int i = 1; i < idx; i++) chk("b2b_gap", 320'(acc_cyc[i] - acc_cyc[i-1]), 320'd7);
    @(posedge clk);
    #1;

    reset_mid_busy();

    for (int k = 1; k < 3; k++) begin
      sel = k;
      #1;
      zero_test();
      random_inverse(100);
      random_forward(10);
      reset_mid_busy();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
